// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting channels and the round-robin
// arbiter. The master side drives requests and the done strobe; the slave
// side (the arbiter) drives the grant outputs.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] gnt_onehot;
    logic       timeout;
    logic       busy;

    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_valid,
        input  gnt_onehot,
        input  timeout,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_valid,
        output gnt_onehot,
        output timeout,
        output busy
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-until-done, a bounded hold time and
// a one-cycle release gap. The search for a new owner starts one position
// after the previous owner, so a channel that keeps requesting is served
// within seven other grants. Every output comes straight from a flop.
module rr_arbiter8 #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Last count value of a grant that is allowed to run to the limit.
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT - 32'd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

    // Returns {found, index} of the first set request at or after p, mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'b0000;
        // Walk from the farthest candidate back to p so the nearest one wins.
        for (int k = 7; k >= 0; k--) begin
            cand = p + 3'(k);
            res  = r[cand] ? {1'b1, cand} : res;
        end
        return res;
    endfunction

    // 3-to-8 one-hot decode of a grant index.
    function automatic logic [7:0] dec3to8(input logic [2:0] i);
        return 8'h01 << i;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [7:0]    gnt_onehot_q, gnt_onehot_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic [3:0]    pick_s;

    assign pick_s = rr_pick(bus.req, ptr_q);

    // Next-state, pointer, hold counter and next registered outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    gnt_idx_d = pick_s[2:0];
                    cnt_d     = {CW{1'b0}};
                    state_d   = ST_GRANT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // done outranks withdrawal, which outranks the hold limit.
                if (bus.done || !bus.req[gnt_idx_q]) begin
                    state_d = ST_GAP;
                    ptr_d   = gnt_idx_q + 3'd1;
                end else if (cnt_q == LIMIT) begin
                    state_d   = ST_GAP;
                    ptr_d     = gnt_idx_q + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gnt_valid_d  = (state_d == ST_GRANT);
        busy_d       = (state_d != ST_IDLE);
        gnt_onehot_d = gnt_valid_d ? dec3to8(gnt_idx_d) : 8'h00;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 3'd0;
            cnt_q        <= {CW{1'b0}};
            gnt_idx_q    <= 3'd0;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= 8'h00;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_onehot_q <= gnt_onehot_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.gnt_onehot = gnt_onehot_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 built with a short hold limit (TIMEOUT=4).
// Each table row gives the inputs held for one clock and the outputs expected
// just after that edge; an asynchronous-reset sequence is written out by hand.
module tb_rr_arbiter8;

    logic clk;
    logic rst_n;

    rr_arbiter8_if bus();

    rr_arbiter8 #(.TIMEOUT(4), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rb;
        logic [7:0] req;
        logic       done;
        logic       v;
        logic [2:0] idx;
        logic       tmo;
        logic       busy;
        logic       cp;
        logic [2:0] ptr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic rb, input logic [7:0] req, input logic done,
                                input logic v, input logic [2:0] idx, input logic tmo,
                                input logic busy, input logic cp, input logic [2:0] ptr);
        vec_t e;
        e.rb = rb; e.req = req; e.done = done; e.v = v; e.idx = idx;
        e.tmo = tmo; e.busy = busy; e.cp = cp; e.ptr = ptr;
        vecs.push_back(e);
    endfunction

    task automatic check_out(input string name, input logic v, input logic [2:0] idx,
                             input logic tmo, input logic busy);
        logic [7:0] oh;
        oh = v ? (8'h01 << idx) : 8'h00;
        checks++;
        if (bus.gnt_valid !== v || bus.gnt_idx !== idx || bus.gnt_onehot !== oh ||
            bus.timeout !== tmo || bus.busy !== busy) begin
            errors++;
            $display("FAIL %s got v=%0b idx=%0d oh=%02h to=%0b busy=%0b exp v=%0b idx=%0d oh=%02h to=%0b busy=%0b",
                     name, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout, bus.busy,
                     v, idx, oh, tmo, busy);
        end
    endtask

    task automatic check_ptr(input string name, input logic [2:0] p);
        checks++;
        if (dut.ptr_q !== p) begin
            errors++;
            $display("FAIL %s ptr got %0d exp %0d", name, dut.ptr_q, p);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;

        // 1: single requester 2, done in the third grant cycle
        add(1'b1, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3);
        add(1'b0, 8'h04, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 3'd3);
        add(1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0);
        // 2: all requesting, done in the first cycle of every grant
        for (int k = 0; k < 9; k++) begin
            add((k == 0), 8'hFF, 1'b0, 1'b1, 3'(k % 8), 1'b0, 1'b1, 1'b0, 3'd0);
            add(1'b0, 8'hFF, 1'b1, 1'b0, 3'(k % 8), 1'b0, 1'b1, 1'b1, 3'((k + 1) % 8));
            add(1'b0, 8'hFF, 1'b0, 1'b0, 3'(k % 8), 1'b0, 1'b0, 1'b0, 3'd0);
        end
        // 3: wrap-around from 7 to 0 and back to 7
        add(1'b1, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h80, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 1'b1, 3'd0);
        add(1'b0, 8'h81, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0);
        add(1'b0, 8'h81, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h81, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd1);
        add(1'b0, 8'h81, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        add(1'b0, 8'h81, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b1, 3'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0);
        // 4: hold limit of 4 cycles, timeout pulse in GAP, re-grant; done ignored outside GRANT
        add(1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd5);
        add(1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 3'd5);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0);
        // 5: owner withdraws in its second grant cycle while req=0A
        add(1'b1, 8'h0A, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h0A, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h08, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 3'd2);
        add(1'b0, 8'h0A, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
        add(1'b0, 8'h0A, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h0A, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 3'd4);
        add(1'b0, 8'h0A, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0);
        add(1'b0, 8'h0A, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 3'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
        // 7: done coincides with the hold limit, no timeout pulse
        add(1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0);
        add(1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 3'd5);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset state
        do_reset();
        #1;
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check_ptr("reset", 3'd0);

        foreach (vecs[n]) begin
            if (vecs[n].rb) begin
                do_reset();
            end
            bus.req  = vecs[n].req;
            bus.done = vecs[n].done;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", n), vecs[n].v, vecs[n].idx, vecs[n].tmo, vecs[n].busy);
            if (vecs[n].cp) begin
                check_ptr($sformatf("vec%0d", n), vecs[n].ptr);
            end
        end

        // 6: asynchronous reset in the middle of a grant to 5 (ptr moved to 3 first)
        do_reset();
        bus.req = 8'h04;
        @(posedge clk); #1;
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
        bus.req  = 8'h20;
        @(posedge clk); #1;
        check_ptr("rst_pre_ptr", 3'd3);
        @(posedge clk); #1;
        check_out("rst_pre_grant", 1'b1, 3'd5, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 3'd0, 1'b0, 1'b0);
        check_ptr("rst_async", 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("rst_regrant", 1'b1, 3'd5, 1'b0, 1'b1);
        check_ptr("rst_regrant", 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
